// File: rtl/multi_pwm_fader.sv
// Multi-channel PWM fader: one shared prescaler/period/step timebase drives CHANNELS
// outputs, each running OFF, FIXED, TRIANGLE (breathing) or RAMP_TO (one-shot fade).
module multi_pwm_fader #(
    parameter int CHANNELS    = 4,
    parameter int RESOLUTION  = 8,
    parameter int DVSR        = 48,
    parameter int GRAD_THRESH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_we,
    input  logic [$clog2(CHANNELS):0]   cfg_ch,
    input  logic [1:0]                  cfg_mode,
    input  logic [RESOLUTION:0]         cfg_duty,
    output logic [CHANNELS-1:0]         pwm_out,
    output logic                        period_start,
    output logic [CHANNELS-1:0]         ramp_done
);

    localparam int PW = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int SW = (GRAD_THRESH > 1) ? $clog2(GRAD_THRESH) : 1;
    localparam int CW = $clog2(CHANNELS) + 1;
    localparam logic [RESOLUTION:0] MAX_DUTY = {1'b1, {RESOLUTION{1'b0}}};

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_FIXED = 2'b01,
        MODE_TRI   = 2'b10,
        MODE_RAMP  = 2'b11
    } mode_e;

    if (DVSR < 1) begin : g_dvsr_check
        $error("multi_pwm_fader: DVSR must be >= 1");
    end
    if (GRAD_THRESH < 1) begin : g_grad_check
        $error("multi_pwm_fader: GRAD_THRESH must be >= 1");
    end

    logic [PW-1:0]          q_q, q_d;
    logic [RESOLUTION-1:0]  d_q, d_d;
    logic [SW-1:0]          s_q, s_d;
    logic                   tick;
    logic                   step;

    mode_e                  mode_q   [CHANNELS];
    mode_e                  mode_d   [CHANNELS];
    logic [RESOLUTION:0]    target_q [CHANNELS];
    logic [RESOLUTION:0]    target_d [CHANNELS];
    logic [RESOLUTION:0]    cur_q    [CHANNELS];
    logic [RESOLUTION:0]    cur_d    [CHANNELS];
    logic [RESOLUTION:0]    eff_q    [CHANNELS];
    logic [RESOLUTION:0]    eff_d    [CHANNELS];
    logic [CHANNELS-1:0]    dir_dn_q, dir_dn_d;
    logic [CHANNELS-1:0]    pwm_q, pwm_d;
    logic [CHANNELS-1:0]    done_q, done_d;
    logic [RESOLUTION:0]    wr_duty;

    always_comb begin
        tick         = (q_q == PW'(DVSR - 1));
        period_start = tick && (d_q == {RESOLUTION{1'b1}});
        step         = period_start && (s_q == SW'(GRAD_THRESH - 1));
        q_d          = tick ? '0 : q_q + 1'b1;
        d_d          = tick ? d_q + 1'b1 : d_q;
        s_d          = s_q;
        if (period_start) begin
            s_d = step ? '0 : s_q + 1'b1;
        end
    end

    // Config port is a plain write strobe: cfg_* are consumed in any clk with cfg_we=1,
    // there is no backpressure, and writes to channels >= CHANNELS are dropped.
    assign wr_duty = (cfg_duty > MAX_DUTY) ? MAX_DUTY : cfg_duty;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            mode_d[i]   = mode_q[i];
            target_d[i] = target_q[i];
            cur_d[i]    = cur_q[i];
            dir_dn_d[i] = dir_dn_q[i];
            done_d[i]   = 1'b0;
            eff_d[i]    = period_start ? cur_q[i] : eff_q[i];
            pwm_d[i]    = (mode_q[i] != MODE_OFF) && ({1'b0, d_q} < eff_q[i]);

            // A write to this channel takes priority over a coincident step.
            if (cfg_we && (cfg_ch == CW'(i))) begin
                mode_d[i]   = mode_e'(cfg_mode);
                target_d[i] = wr_duty;
                dir_dn_d[i] = 1'b0;
                case (mode_e'(cfg_mode))
                    MODE_OFF:   cur_d[i] = '0;
                    MODE_FIXED: cur_d[i] = wr_duty;
                    MODE_RAMP:  done_d[i] = (wr_duty == cur_q[i]);
                    default:    ;
                endcase
            end else if (step) begin
                case (mode_q[i])
                    MODE_TRI: begin
                        if (!dir_dn_q[i]) begin
                            if (cur_q[i] == MAX_DUTY) begin
                                cur_d[i]    = cur_q[i] - 1'b1;
                                dir_dn_d[i] = 1'b1;
                            end else begin
                                cur_d[i]    = cur_q[i] + 1'b1;
                                dir_dn_d[i] = (cur_q[i] == MAX_DUTY - 1'b1);
                            end
                        end else begin
                            if (cur_q[i] == '0) begin
                                cur_d[i]    = cur_q[i] + 1'b1;
                                dir_dn_d[i] = 1'b0;
                            end else begin
                                cur_d[i]    = cur_q[i] - 1'b1;
                                dir_dn_d[i] = (cur_q[i] != 1);
                            end
                        end
                    end
                    MODE_RAMP: begin
                        if (cur_q[i] < target_q[i]) begin
                            cur_d[i]  = cur_q[i] + 1'b1;
                            done_d[i] = (cur_q[i] + 1'b1 == target_q[i]);
                        end else if (cur_q[i] > target_q[i]) begin
                            cur_d[i]  = cur_q[i] - 1'b1;
                            done_d[i] = (cur_q[i] - 1'b1 == target_q[i]);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q      <= '0;
            d_q      <= '0;
            s_q      <= '0;
            pwm_q    <= '0;
            done_q   <= '0;
            dir_dn_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                mode_q[i]   <= MODE_OFF;
                target_q[i] <= '0;
                cur_q[i]    <= '0;
                eff_q[i]    <= '0;
            end
        end else begin
            q_q      <= q_d;
            d_q      <= d_d;
            s_q      <= s_d;
            pwm_q    <= pwm_d;
            done_q   <= done_d;
            dir_dn_q <= dir_dn_d;
            for (int i = 0; i < CHANNELS; i++) begin
                mode_q[i]   <= mode_d[i];
                target_q[i] <= target_d[i];
                cur_q[i]    <= cur_d[i];
                eff_q[i]    <= eff_d[i];
            end
        end
    end

    assign pwm_out   = pwm_q;
    assign ramp_done = done_q;

endmodule

// File: tb/tb_multi_pwm_fader.sv
// Bench for multi_pwm_fader: a cycle-count based reference model predicts every output
// per clk into a queue; a negedge monitor pops and compares.
module tb_multi_pwm_fader;

    localparam int CH   = 4;
    localparam int RES  = 4;
    localparam int DV   = 2;
    localparam int GT   = 2;
    localparam int PER  = DV * (1 << RES);
    localparam int MAXD = 1 << RES;
    localparam int CW   = $clog2(CH) + 1;
    localparam int DW   = RES + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_we = 1'b0;
    logic [CW-1:0] cfg_ch = '0;
    logic [1:0]    cfg_mode = '0;
    logic [DW-1:0] cfg_duty = '0;
    logic [CH-1:0] pwm_out;
    logic          period_start;
    logic [CH-1:0] ramp_done;

    multi_pwm_fader #(
        .CHANNELS(CH), .RESOLUTION(RES), .DVSR(DV), .GRAD_THRESH(GT)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
        .cfg_duty(cfg_duty), .pwm_out(pwm_out), .period_start(period_start),
        .ramp_done(ramp_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic          ps;
        logic [CH-1:0] pwm;
        logic [CH-1:0] rd;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state: duty values as plain integers; triangle tracked as a
    // position k on a 2*MAXD-long cycle, duty = k folded at MAXD.
    int m_mode [CH];
    int m_tgt  [CH];
    int m_cur  [CH];
    int m_eff  [CH];
    int m_k    [CH];
    int m_n;
    bit m_live;

    function automatic void check(input string name, input logic [15:0] act,
                                  input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
        end
    endfunction

    always @(posedge clk) begin : model
        int   ph, t, ch_i;
        bit   ps, stp, wr;
        exp_t e;
        if (!rst) begin
            for (int i = 0; i < CH; i++) begin
                m_mode[i] = 0; m_tgt[i] = 0; m_cur[i] = 0; m_eff[i] = 0; m_k[i] = 0;
            end
            m_n    = 0;
            m_live = 1'b0;
            exp_q.delete();
        end else begin
            ph   = m_n % PER;
            ps   = (ph == PER - 1);
            stp  = ps && (((m_n / PER) % GT) == GT - 1);
            wr   = cfg_we && (int'(cfg_ch) < CH);
            ch_i = int'(cfg_ch);
            t    = (int'(cfg_duty) > MAXD) ? MAXD : int'(cfg_duty);
            e    = '0;
            for (int i = 0; i < CH; i++) begin
                e.pwm[i] = (m_mode[i] != 0) && ((ph / DV) < m_eff[i]);
                if (ps) m_eff[i] = m_cur[i];
                if (wr && ch_i == i) begin
                    m_mode[i] = int'(cfg_mode);
                    m_tgt[i]  = t;
                    if (m_mode[i] == 0) m_cur[i] = 0;
                    if (m_mode[i] == 1) m_cur[i] = t;
                    if (m_mode[i] == 2) m_k[i] = m_cur[i];
                    if (m_mode[i] == 3 && t == m_cur[i]) e.rd[i] = 1'b1;
                end else if (stp && m_mode[i] == 2) begin
                    m_k[i]   = (m_k[i] + 1) % (2 * MAXD);
                    m_cur[i] = (m_k[i] <= MAXD) ? m_k[i] : 2 * MAXD - m_k[i];
                end else if (stp && m_mode[i] == 3 && m_cur[i] != m_tgt[i]) begin
                    m_cur[i] = m_cur[i] + ((m_tgt[i] > m_cur[i]) ? 1 : -1);
                    if (m_cur[i] == m_tgt[i]) e.rd[i] = 1'b1;
                end
            end
            m_n++;
            e.ps = ((m_n % PER) == PER - 1);
            exp_q.push_back(e);
            m_live = 1'b1;
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && m_live) begin
            if (exp_q.size() == 0) begin
                check("exp_queue_empty", 16'd1, 16'd0);
            end else begin
                e = exp_q.pop_front();
                check("period_start", 16'(period_start), 16'(e.ps));
                check("pwm_out", 16'(pwm_out), 16'(e.pwm));
                check("ramp_done", 16'(ramp_done), 16'(e.rd));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int ch, input int mode, input int duty);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_ch   = CW'(ch);
        cfg_mode = 2'(mode);
        cfg_duty = DW'(duty);
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    // Issue a write in exactly the clk where a duty step fires.
    task automatic wr_on_step(input int ch, input int mode, input int duty);
        bit found = 1'b0;
        for (int k = 0; k < PER * GT + 4; k++) begin
            @(negedge clk);
            if ((m_n % PER) == PER - 1 && ((m_n / PER) % GT) == GT - 1) begin
                found = 1'b1;
                break;
            end
        end
        check("step_align_timeout", 16'(!found), 16'd0);
        cfg_we   = 1'b1;
        cfg_ch   = CW'(ch);
        cfg_mode = 2'(mode);
        cfg_duty = DW'(duty);
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic wait_phase(input int ph);
        bit found = 1'b0;
        for (int k = 0; k < PER + 2; k++) begin
            @(negedge clk);
            if ((m_n % PER) == ph) begin
                found = 1'b1;
                break;
            end
        end
        check("phase_align_timeout", 16'(!found), 16'd0);
    endtask

    task automatic reset_cycle();
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_async_pwm", 16'(pwm_out), 16'd0);
        check("rst_async_done", 16'(ramp_done), 16'd0);
        check("rst_async_ps", 16'(period_start), 16'd0);
        repeat (3) @(negedge clk);
        check("rst_hold_pwm", 16'(pwm_out), 16'd0);
        check("rst_hold_done", 16'(ramp_done), 16'd0);
        check("rst_hold_ps", 16'(period_start), 16'd0);
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout @%0t", $time);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        reset_cycle();
        idle(2 * PER);

        wr(0, 1, 4);
        wr(1, 1, 0);
        wr(2, 1, MAXD);
        wr(3, 1, MAXD + 9);
        idle(3 * PER);

        wait_phase(PER / 2);
        wr(0, 1, 12);
        idle(2 * PER);

        wr(1, 2, 0);
        idle(2 * MAXD * GT * PER + 2 * PER);

        wr(2, 1, 2);
        idle(2 * PER);
        wr(2, 3, 5);
        idle(5 * GT * PER);
        wr(CH, 1, 9);
        wr(7, 3, 3);
        idle(PER);
        wr(2, 3, 5);
        idle(PER);

        wr(3, 3, 0);
        idle(6 * GT * PER);
        wr_on_step(3, 3, 2);
        idle(10 * GT * PER);
        wr_on_step(1, 2, 0);
        idle(3 * GT * PER);

        repeat (80) begin
            idle($urandom_range(0, 120));
            if ($urandom_range(0, 5) == 0)
                wr_on_step($urandom_range(0, CH - 1), $urandom_range(0, 3),
                           $urandom_range(0, MAXD + 4));
            else
                wr($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, MAXD + 4));
        end

        wr(0, 1, 3);
        wr(0, 3, MAXD);
        idle(3 * GT * PER);
        reset_cycle();
        idle(3 * PER);
        wr(1, 1, 7);
        idle(2 * PER);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
